// File: rtl/cov_bin_pkg.sv
// Shared types and helpers for the coverage bin tracker.
// Latency: none (types and constant functions only).
// Backpressure: none.
package cov_bin_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  function automatic int calc_bin_w(input int cmd_w, input int adr_w);
    return cmd_w + adr_w;
  endfunction

  function automatic int calc_num_bins(input int bin_w);
    return 1 << bin_w;
  endfunction

  // Counts set bits across up to MAX_CH channel flags.
  function automatic logic [3:0] popcount8(input logic [MAX_CH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/cov_bin_tracker_if.sv
// Sample taps, control and observation signals of the coverage bin tracker.
// Latency: n/a (wiring only).
// Backpressure: none; sampling is a pure tap, readout always answers next cycle.
interface cov_bin_tracker_if
  import cov_bin_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int ADR_W  = 4,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  localparam int BIN_W = calc_bin_w(CMD_W, ADR_W);
  localparam int RCW   = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0]           in_valid;
  logic [NUM_CH*CMD_W-1:0]     in_cmd;
  logic [NUM_CH*ADR_W-1:0]     in_adr;
  logic                        freeze;
  logic                        clr_req;
  logic                        clr_ack;
  logic [NUM_CH-1:0]           new_hit;
  logic [NUM_CH*BIN_W-1:0]     new_bin;
  logic [NUM_CH*(BIN_W+1)-1:0] uniq_cnt;
  logic [BIN_W:0]              union_cnt;
  logic [NUM_CH*CNT_W-1:0]     sample_cnt;
  logic [NUM_CH-1:0]           cov_done;
  logic                        union_done;
  logic                        rd_req;
  logic [RCW-1:0]              rd_ch;
  logic [BIN_W-1:0]            rd_bin;
  logic                        rd_valid;
  logic                        rd_hit;

  modport master (
    output in_valid, in_cmd, in_adr, freeze, clr_req, rd_req, rd_ch, rd_bin,
    input  clr_ack, new_hit, new_bin, uniq_cnt, union_cnt, sample_cnt,
           cov_done, union_done, rd_valid, rd_hit
  );

  modport slave (
    input  in_valid, in_cmd, in_adr, freeze, clr_req, rd_req, rd_ch, rd_bin,
    output clr_ack, new_hit, new_bin, uniq_cnt, union_cnt, sample_cnt,
           cov_done, union_done, rd_valid, rd_hit
  );

endinterface

// File: rtl/cov_bin_chan.sv
// One channel's hit bitmap, unique/sample counters, new-bin event and done flag.
// Latency: 1 cycle from accepted sample to counters/flags/event.
// Backpressure: none; every accepted sample is absorbed.
module cov_bin_chan
  import cov_bin_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             smp_vld_i,
  input  logic [BIN_W-1:0] smp_bin_i,
  input  logic [BIN_W-1:0] rd_bin_i,
  output logic             rd_hit_o,
  output logic             new_hit_o,
  output logic [BIN_W-1:0] new_bin_o,
  output logic [BIN_W:0]   uniq_cnt_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic             cov_done_o
);
  localparam int NUM_BINS = calc_num_bins(BIN_W);
  localparam logic [BIN_W:0] FULL = (BIN_W+1)'(NUM_BINS);

  logic [NUM_BINS-1:0] hit_q;
  logic [BIN_W:0]      uniq_cnt_q, uniq_cnt_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic                new_hit_q, cov_done_q, first_hit;
  logic [BIN_W-1:0]    new_bin_q;

  // First-time hit detection and saturating sample count.
  always_comb begin
    first_hit    = smp_vld_i & ~hit_q[smp_bin_i];
    uniq_cnt_d   = uniq_cnt_q + {{BIN_W{1'b0}}, first_hit};
    sample_cnt_d = sample_cnt_q;
    if (smp_vld_i && (sample_cnt_q != '1)) sample_cnt_d = sample_cnt_q + CNT_W'(1);
  end

  // Bitmap, counters and event registers; clear wins over any sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q        <= '0;
      uniq_cnt_q   <= '0;
      sample_cnt_q <= '0;
      new_hit_q    <= 1'b0;
      new_bin_q    <= '0;
      cov_done_q   <= 1'b0;
    end else if (clr_i) begin
      hit_q        <= '0;
      uniq_cnt_q   <= '0;
      sample_cnt_q <= '0;
      new_hit_q    <= 1'b0;
      new_bin_q    <= '0;
      cov_done_q   <= 1'b0;
    end else begin
      if (smp_vld_i) hit_q[smp_bin_i] <= 1'b1;
      uniq_cnt_q   <= uniq_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      new_hit_q    <= first_hit;
      if (first_hit) new_bin_q <= smp_bin_i;
      cov_done_q   <= cov_done_q | (uniq_cnt_d == FULL);
    end
  end

  assign rd_hit_o     = hit_q[rd_bin_i];
  assign new_hit_o    = new_hit_q;
  assign new_bin_o    = new_bin_q;
  assign uniq_cnt_o   = uniq_cnt_q;
  assign sample_cnt_o = sample_cnt_q;
  assign cov_done_o   = cov_done_q;

endmodule

// File: rtl/cov_bin_tracker.sv
// Per-channel and union (cmd,adr) cross-coverage tracker with clear FSM and readout.
// Latency: 1 cycle for counters/flags/events and for readout responses.
// Backpressure: none; samples are dropped while frozen or during the clear sequence.
module cov_bin_tracker
  import cov_bin_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int ADR_W  = 4,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  cov_bin_tracker_if.slave bus
);
  localparam int BIN_W    = calc_bin_w(CMD_W, ADR_W);
  localparam int NUM_BINS = calc_num_bins(BIN_W);
  localparam int UCW      = BIN_W + 1;
  localparam int RCW      = $clog2(NUM_CH + 1);
  localparam logic [UCW-1:0] FULL = UCW'(NUM_BINS);

  state_e              state_q, state_d;
  logic                clr_go, clr_ack;
  logic [NUM_CH-1:0]   accept, union_new, chan_rd, new_hit, cov_done;
  logic [BIN_W-1:0]    bin [NUM_CH];
  logic [NUM_BINS-1:0] ubit_q, ubit_d;
  logic [UCW-1:0]      union_cnt_q, union_cnt_d;
  logic                union_done_q, rd_valid_q, rd_hit_q, rd_sel;
  logic [NUM_CH*BIN_W-1:0] new_bin;
  logic [NUM_CH*UCW-1:0]   uniq_cnt;
  logic [NUM_CH*CNT_W-1:0] sample_cnt;

  // Clear sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Clear sequencer: one wipe cycle, then one acknowledge cycle; requests mid-sequence are ignored.
  always_comb begin
    state_d = state_q;
    clr_go  = 1'b0;
    clr_ack = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.clr_req) state_d = ST_CLEAR;
      ST_CLEAR: begin clr_go = 1'b1; state_d = ST_ACK; end
      ST_ACK:   begin clr_ack = 1'b1; state_d = ST_IDLE; end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bin index per channel ({cmd,adr}) and the accept qualifier.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      bin[c]    = {bus.in_cmd[c*CMD_W +: CMD_W], bus.in_adr[c*ADR_W +: ADR_W]};
      accept[c] = bus.in_valid[c] & ~bus.freeze & (state_q == ST_IDLE) & ~bus.clr_req;
    end
  end

  // Union update: a bin counts once even if several channels hit it in the same cycle.
  always_comb begin
    ubit_d    = ubit_q;
    union_new = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      union_new[c] = accept[c] & ~ubit_q[bin[c]];
      for (int j = 0; j < c; j++)
        if (accept[j] && (bin[j] == bin[c])) union_new[c] = 1'b0;
      if (accept[c]) ubit_d[bin[c]] = 1'b1;
    end
    union_cnt_d = union_cnt_q + UCW'(popcount8(MAX_CH'(union_new)));
  end

  // Union bitmap, count and sticky done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ubit_q       <= '0;
      union_cnt_q  <= '0;
      union_done_q <= 1'b0;
    end else if (clr_go) begin
      ubit_q       <= '0;
      union_cnt_q  <= '0;
      union_done_q <= 1'b0;
    end else begin
      ubit_q       <= ubit_d;
      union_cnt_q  <= union_cnt_d;
      union_done_q <= union_done_q | (union_cnt_d == FULL);
    end
  end

  // Readout select: channels, then the union, anything above reads as 0.
  always_comb begin
    rd_sel = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (bus.rd_ch == RCW'(c)) rd_sel = chan_rd[c];
    if (bus.rd_ch == RCW'(NUM_CH)) rd_sel = ubit_q[bus.rd_bin];
  end

  // Readout response register; sees bitmap contents from before this edge's updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) rd_hit_q <= rd_sel;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cov_bin_chan #(.BIN_W(BIN_W), .CNT_W(CNT_W)) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (clr_go),
      .smp_vld_i    (accept[c]),
      .smp_bin_i    (bin[c]),
      .rd_bin_i     (bus.rd_bin),
      .rd_hit_o     (chan_rd[c]),
      .new_hit_o    (new_hit[c]),
      .new_bin_o    (new_bin[c*BIN_W +: BIN_W]),
      .uniq_cnt_o   (uniq_cnt[c*UCW +: UCW]),
      .sample_cnt_o (sample_cnt[c*CNT_W +: CNT_W]),
      .cov_done_o   (cov_done[c])
    );
  end

  assign bus.clr_ack    = clr_ack;
  assign bus.new_hit    = new_hit;
  assign bus.new_bin    = new_bin;
  assign bus.uniq_cnt   = uniq_cnt;
  assign bus.union_cnt  = union_cnt_q;
  assign bus.sample_cnt = sample_cnt;
  assign bus.cov_done   = cov_done;
  assign bus.union_done = union_done_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_hit     = rd_hit_q;

endmodule

// File: tb/tb_cov_bin_tracker.sv
// Randomised and directed bench for cov_bin_tracker against a behavioural coverage model.
// Latency: model predicts outputs one cycle after each sampling edge.
// Backpressure: none exercised; inputs are free-running taps.
module tb_cov_bin_tracker;
  localparam int CMD_W = 4, ADR_W = 4, NUM_CH = 2, CNT_W = 4;
  localparam int BIN_W = CMD_W + ADR_W;
  localparam int NUM_BINS = 1 << BIN_W;
  localparam int UW = BIN_W + 1;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  cov_bin_tracker_if #(.CMD_W(CMD_W), .ADR_W(ADR_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  cov_bin_tracker #(.CMD_W(CMD_W), .ADR_W(ADR_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_uniq(input int c); return int'(bus.uniq_cnt[c*UW +: UW]); endfunction
  function automatic int f_scnt(input int c); return int'(bus.sample_cnt[c*CNT_W +: CNT_W]); endfunction
  function automatic int f_nbin(input int c); return int'(bus.new_bin[c*BIN_W +: BIN_W]); endfunction

  // ---------------- behavioural model ----------------
  bit m_hit  [NUM_CH][NUM_BINS];
  bit m_ubit [NUM_BINS];
  int m_ucnt [NUM_CH];
  int m_scnt [NUM_CH];
  bit m_new_hit [NUM_CH];
  int m_new_bin [NUM_CH];
  int m_ucnt_u;
  int m_phase;          // 0 normal, 1 wiping next edge, 2 acknowledging
  bit m_rd_valid, m_rd_hit;

  function automatic void model_wipe();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < NUM_BINS; b++) m_hit[c][b] = 1'b0;
      m_ucnt[c] = 0; m_scnt[c] = 0; m_new_hit[c] = 1'b0;
    end
    for (int b = 0; b < NUM_BINS; b++) m_ubit[b] = 1'b0;
    m_ucnt_u = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_wipe();
      for (int c = 0; c < NUM_CH; c++) m_new_bin[c] = 0;
      m_phase = 0; m_rd_valid = 1'b0; m_rd_hit = 1'b0;
    end else begin
      int rc, rb, b;
      m_rd_valid = bus.rd_req;
      if (bus.rd_req) begin
        rc = int'(bus.rd_ch); rb = int'(bus.rd_bin);
        if (rc < NUM_CH) m_rd_hit = m_hit[rc][rb];
        else if (rc == NUM_CH) m_rd_hit = m_ubit[rb];
        else m_rd_hit = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) m_new_hit[c] = 1'b0;
      if (m_phase == 1) begin
        model_wipe(); m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (bus.clr_req) begin
        m_phase = 1;
      end else if (!bus.freeze) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.in_valid[c]) begin
            b = int'({bus.in_cmd[c*CMD_W +: CMD_W], bus.in_adr[c*ADR_W +: ADR_W]});
            if (m_scnt[c] < SAT) m_scnt[c]++;
            if (!m_hit[c][b]) begin
              m_hit[c][b] = 1'b1; m_ucnt[c]++;
              m_new_hit[c] = 1'b1; m_new_bin[c] = b;
            end
            if (!m_ubit[b]) begin m_ubit[b] = 1'b1; m_ucnt_u++; end
          end
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("new_hit[%0d]", c), bus.new_hit[c], m_new_hit[c]);
      if (m_new_hit[c]) chk($sformatf("new_bin[%0d]", c), f_nbin(c), m_new_bin[c]);
      chk($sformatf("uniq_cnt[%0d]", c), f_uniq(c), m_ucnt[c]);
      chk($sformatf("sample_cnt[%0d]", c), f_scnt(c), m_scnt[c]);
      chk($sformatf("cov_done[%0d]", c), bus.cov_done[c], m_ucnt[c] == NUM_BINS);
    end
    chk("union_cnt", bus.union_cnt, m_ucnt_u);
    chk("union_done", bus.union_done, m_ucnt_u == NUM_BINS);
    chk("clr_ack", bus.clr_ack, m_phase == 2);
    chk("rd_valid", bus.rd_valid, m_rd_valid);
    if (m_rd_valid) chk("rd_hit", bus.rd_hit, m_rd_hit);
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask

  task automatic set_ch(input int c, input bit v, input int b);
    bus.in_valid[c] = v;
    bus.in_cmd[c*CMD_W +: CMD_W] = CMD_W'(b >> ADR_W);
    bus.in_adr[c*ADR_W +: ADR_W] = ADR_W'(b);
  endtask

  task automatic idle_inputs();
    bus.in_valid = '0; bus.in_cmd = '0; bus.in_adr = '0;
    bus.freeze = 1'b0; bus.clr_req = 1'b0;
    bus.rd_req = 1'b0; bus.rd_ch = '0; bus.rd_bin = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    step(); step();
    chk("rst uniq0", f_uniq(0), 0);
    chk("rst union_cnt", bus.union_cnt, 0);
    chk("rst clr_ack", bus.clr_ack, 0);
    chk("rst rd_valid", bus.rd_valid, 0);
    rst_n = 1'b1;

    // Same bin twice on ch0: one event, two samples.
    set_ch(0, 1, 'h35); step();
    chk("A new_hit", bus.new_hit, 1);
    chk("A new_bin", f_nbin(0), 'h35);
    set_ch(0, 1, 'h35); step();
    chk("A new_hit repeat", bus.new_hit, 0);
    chk("A uniq0", f_uniq(0), 1);
    chk("A scnt0", f_scnt(0), 2);
    chk("A union", bus.union_cnt, 1);
    chk("A model uniq0", m_ucnt[0], 1);
    set_ch(0, 0, 0);

    // Both channels on the same bin in one cycle.
    do_reset();
    set_ch(0, 1, 'h35); set_ch(1, 1, 'h35); step();
    chk("B uniq0", f_uniq(0), 1);
    chk("B uniq1", f_uniq(1), 1);
    chk("B union", bus.union_cnt, 1);
    chk("B model union", m_ucnt_u, 1);
    do_reset();
    set_ch(0, 1, 'h11); set_ch(1, 1, 'h22); step();
    chk("B2 union", bus.union_cnt, 2);
    set_ch(0, 0, 0); set_ch(1, 0, 0);

    // Readout is read-before-write; union select and out-of-range select.
    do_reset();
    set_ch(0, 1, 'h35); bus.rd_req = 1'b1; bus.rd_ch = 2'd0; bus.rd_bin = 8'h35; step();
    chk("C rd_valid", bus.rd_valid, 1);
    chk("C rd_hit first", bus.rd_hit, 0);
    set_ch(0, 0, 0); step();
    chk("C rd_hit repeat", bus.rd_hit, 1);
    bus.rd_ch = 2'd2; step();
    chk("C rd_hit union", bus.rd_hit, 1);
    bus.rd_ch = 2'd3; step();
    chk("C rd_hit oob", bus.rd_hit, 0);
    chk("C rd_valid oob", bus.rd_valid, 1);
    bus.rd_req = 1'b0; step();
    chk("C rd_valid off", bus.rd_valid, 0);

    // Full sweep on ch0.
    do_reset();
    for (int b = 0; b < NUM_BINS; b++) begin
      set_ch(0, 1, b); step();
      if (b == NUM_BINS - 2) chk("D cov_done early", bus.cov_done, 0);
    end
    set_ch(0, 0, 0);
    chk("D cov_done", bus.cov_done, 1);
    chk("D union_done", bus.union_done, 1);
    chk("D uniq0", f_uniq(0), 256);
    chk("D uniq1", f_uniq(1), 0);

    // Sample counter saturation.
    for (int i = 0; i < 20; i++) begin set_ch(1, 1, $urandom_range(0, 255)); step(); end
    set_ch(1, 0, 0);
    chk("E scnt1 sat", f_scnt(1), 15);

    // Clear with samples held valid.
    set_ch(0, 1, 7); set_ch(1, 1, 9); bus.clr_req = 1'b1; step();
    chk("F clr_ack req", bus.clr_ack, 0);
    chk("F uniq0 held", f_uniq(0), 256);
    chk("F scnt0 held", f_scnt(0), 15);
    step();
    chk("F clr_ack", bus.clr_ack, 1);
    chk("F uniq0 clr", f_uniq(0), 0);
    chk("F scnt1 clr", f_scnt(1), 0);
    chk("F union clr", bus.union_cnt, 0);
    chk("F cov_done clr", bus.cov_done, 0);
    chk("F union_done clr", bus.union_done, 0);
    bus.clr_req = 1'b0; step();
    chk("F clr_ack off", bus.clr_ack, 0);
    chk("F scnt0 drop", f_scnt(0), 0);
    step();
    chk("F scnt0 resume", f_scnt(0), 1);
    chk("F union resume", bus.union_cnt, 2);

    // Freeze blocks sampling.
    bus.freeze = 1'b1; step(); step(); step();
    chk("G scnt0 frozen", f_scnt(0), 1);
    chk("G union frozen", bus.union_cnt, 2);
    idle_inputs();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_ch(c, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 31));
      bus.freeze  = ($urandom_range(0, 9) == 0);
      bus.clr_req = ($urandom_range(0, 59) == 0);
      bus.rd_req  = 1'($urandom);
      bus.rd_ch   = 2'($urandom_range(0, 3));
      bus.rd_bin  = 8'($urandom_range(0, 63));
      step();
      if ($urandom_range(0, 699) == 0) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    idle_inputs();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
